// File: rtl/ysyx_sq.sv
// Post-commit store queue: drains retired stores to the data-memory write port
// in program order and offers store-to-load forwarding for younger loads.
module ysyx_sq #(
    parameter int SQ_SIZE = 4,
    parameter int XLEN    = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rou_valid,
    input  logic            rou_store,
    input  logic [4:0]      rou_alu,
    input  logic [XLEN-1:0] rou_waddr,
    input  logic [XLEN-1:0] rou_wdata,
    output logic            sq_ready,
    output logic            sq_empty,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_done,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    output logic            ld_fwd_hit,
    output logic [XLEN-1:0] ld_fwd_data,
    output logic            ld_stall
);

    localparam int PW = $clog2(SQ_SIZE);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    logic [XLEN-3:0]    e_addr [SQ_SIZE];
    logic [XLEN-1:0]    e_data [SQ_SIZE];
    logic [3:0]         e_strb [SQ_SIZE];
    logic [SQ_SIZE-1:0] e_vld;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    state_t        state, state_nxt;

    logic          enq, pop;
    logic [1:0]    off;
    logic [3:0]    new_strb;
    logic [XLEN-1:0] new_data;

    logic alu_unused;
    assign alu_unused = ^{rou_alu[4:2], ld_addr[1:0]};

    assign sq_ready = (count != CW'(SQ_SIZE));
    assign sq_empty = (count == '0) && (state == S_IDLE);
    assign enq      = rou_valid && rou_store && sq_ready && !reset;
    assign pop      = (state == S_WAIT) && mem_done;
    assign off      = rou_waddr[1:0];
    assign new_data = rou_wdata << {off, 3'b000};

    // Half at offset 3 loses its upper strobe through 4-bit truncation.
    always_comb begin
        new_strb = 4'hf;
        unique case (rou_alu[1:0])
            2'b00:   new_strb = 4'b0001 << off;
            2'b01:   new_strb = 4'b0011 << off;
            default: new_strb = 4'hf;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (enq && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!enq && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            e_vld <= '0;
            state <= S_IDLE;
        end else begin
            if (pop) begin
                head         <= head + PW'(1);
                e_vld[head]  <= 1'b0;
            end
            if (enq) begin
                tail         <= tail + PW'(1);
                e_vld[tail]  <= 1'b1;
            end
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            e_addr[tail] <= rou_waddr[XLEN-1:2];
            e_data[tail] <= new_data;
            e_strb[tail] <= new_strb;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (count != '0) state_nxt = S_REQ;
            end
            S_REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_nxt = (count_nxt != '0) ? S_REQ : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mem_addr  = mem_valid ? {e_addr[head], 2'b00} : '0;
    assign mem_wdata = mem_valid ? e_data[head] : '0;
    assign mem_wstrb = mem_valid ? e_strb[head] : 4'h0;

    logic            fw_found, fw_full, enq_hit;
    logic [XLEN-1:0] fw_data;
    logic [PW-1:0]   idx;

    // Walk oldest to youngest so the last match seen is nearest tail.
    always_comb begin
        fw_found = 1'b0;
        fw_full  = 1'b0;
        fw_data  = '0;
        idx      = head;
        for (int i = 0; i < SQ_SIZE; i++) begin
            idx = head + PW'(i);
            if (e_vld[idx] && (e_addr[idx] == ld_addr[XLEN-1:2])) begin
                fw_found = 1'b1;
                fw_full  = (e_strb[idx] == 4'hf);
                fw_data  = e_data[idx];
            end
        end
    end

    assign enq_hit     = enq && (rou_waddr[XLEN-1:2] == ld_addr[XLEN-1:2]);
    assign ld_stall    = ld_valid && (enq_hit || (fw_found && !fw_full));
    assign ld_fwd_hit  = ld_valid && fw_found && fw_full && !enq_hit;
    assign ld_fwd_data = ld_fwd_hit ? fw_data : '0;

endmodule

// File: tb/tb_ysyx_sq.sv
// Bench for ysyx_sq: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the store queue.
module tb_ysyx_sq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rou_valid = 1'b0;
    logic        rou_store = 1'b0;
    logic [4:0]  rou_alu = '0;
    logic [31:0] rou_waddr = '0;
    logic [31:0] rou_wdata = '0;
    logic        sq_ready, sq_empty, mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_done = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_fwd_hit, ld_stall;
    logic [31:0] ld_fwd_data;

    ysyx_sq #(.SQ_SIZE(4), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .rou_valid(rou_valid), .rou_store(rou_store), .rou_alu(rou_alu),
        .rou_waddr(rou_waddr), .rou_wdata(rou_wdata),
        .sq_ready(sq_ready), .sq_empty(sq_empty),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_done(mem_done),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    ent_t mq[$];
    int   mst = 0;      // 0 idle, 1 request shown, 2 awaiting ack
    int   errs = 0;
    int   checks = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(logic [4:0] alu, logic [31:0] a, logic [31:0] d);
        ent_t e;
        int off;
        off  = int'(a[1:0]);
        e.wa = a[31:2];
        e.d  = d << (8 * off);
        case (alu[1:0])
            2'b00:   e.s = 4'(1 << off);
            2'b01:   e.s = 4'(3 << off);
            default: e.s = 4'hf;
        endcase
        return e;
    endfunction

    task automatic model_step();
        int  n0;
        bit  enq, pop;
        n0  = mq.size();
        enq = rou_valid && rou_store && (n0 != 4);
        pop = (mst == 2) && mem_done;
        if (pop) void'(mq.pop_front());
        if (enq) mq.push_back(mk(rou_alu, rou_waddr, rou_wdata));
        case (mst)
            0: if (n0 != 0) mst = 1;
            1: if (mem_ready) mst = 2;
            default: if (mem_done) mst = (mq.size() != 0) ? 1 : 0;
        endcase
    endtask

    task automatic model_reset();
        mq.delete();
        mst = 0;
    endtask

    task automatic check_all();
        bit found, full, enqw, e_hit, e_stall;
        logic [31:0] fd;
        ent_t h;
        @(negedge clock);
        found = 0; full = 0; fd = '0;
        foreach (mq[i]) begin
            if (mq[i].wa == ld_addr[31:2]) begin
                found = 1;
                full  = (mq[i].s == 4'hf);
                fd    = mq[i].d;
            end
        end
        enqw = !reset && rou_valid && rou_store && (mq.size() != 4)
               && (rou_waddr[31:2] == ld_addr[31:2]);
        e_hit   = ld_valid && found && full && !enqw;
        e_stall = ld_valid && (enqw || (found && !full));
        chk("sq_ready", sq_ready, mq.size() != 4);
        chk("sq_empty", sq_empty, mq.size() == 0 && mst == 0);
        chk("mem_valid", mem_valid, mst == 1);
        if (mst == 1) begin
            h = mq[0];
            chk("mem_addr", mem_addr, {h.wa, 2'b00});
            chk("mem_wdata", mem_wdata, h.d);
            chk("mem_wstrb", mem_wstrb, h.s);
        end else begin
            chk("mem_addr_idle", mem_addr, 32'h0);
            chk("mem_wstrb_idle", mem_wstrb, 32'h0);
        end
        chk("ld_fwd_hit", ld_fwd_hit, e_hit);
        chk("ld_stall", ld_stall, e_stall);
        chk("ld_fwd_data", ld_fwd_data, e_hit ? fd : 32'h0);
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic cyc();
        check_all();
        tick();
    endtask

    task automatic st(logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        rou_valid = 1'b1;
        rou_store = 1'b1;
        rou_alu   = {3'b000, sz};
        rou_waddr = a;
        rou_wdata = d;
        cyc();
        rou_valid = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (mst != 1 && k < 20) begin
            cyc();
            k++;
        end
        checks++;
        assert (k < 20) else begin
            errs++;
            $error("FAIL wait_req_budget: waited %0d cycles, limit 20", k);
        end
    endtask

    task automatic drain();
        int k = 0;
        mem_ready = 1'b1;
        while (!(mq.size() == 0 && mst == 0) && k < 100) begin
            mem_done = (mst == 2);
            cyc();
            k++;
        end
        mem_done = 1'b0;
        checks++;
        assert (k < 100) else begin
            errs++;
            $error("FAIL drain_budget: waited %0d cycles, limit 100", k);
        end
    endtask

    initial begin
        // reset values
        #3;
        chk("rst_ready", sq_ready, 1);
        chk("rst_empty", sq_empty, 1);
        chk("rst_mvalid", mem_valid, 0);
        chk("rst_ldhit", ld_fwd_hit, 0);
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // single word store, full handshake
        mem_ready = 1'b1;
        st(2'd2, 32'h8000_0004, 32'hDEAD_BEEF);
        cyc();
        check_all();
        chk("t1_valid", mem_valid, 1);
        chk("t1_addr", mem_addr, 32'h8000_0004);
        chk("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t1_wstrb", mem_wstrb, 32'hf);
        tick();
        mem_done = 1'b1;
        cyc();
        mem_done = 1'b0;
        check_all();
        chk("t1_empty", sq_empty, 1);
        tick();

        // byte and half lane shifting
        mem_ready = 1'b0;
        st(2'd0, 32'h8000_0003, 32'h0000_00AB);
        st(2'd1, 32'h8000_0002, 32'h0000_1234);
        wait_req();
        check_all();
        chk("t2_b_strb", mem_wstrb, 32'h8);
        chk("t2_b_data", mem_wdata, 32'hAB00_0000);
        tick();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        mem_done  = 1'b1;
        cyc();
        mem_done = 1'b0;
        check_all();
        chk("t2_h_strb", mem_wstrb, 32'hc);
        chk("t2_h_data", mem_wdata, 32'h1234_0000);
        tick();
        drain();

        // fill, overflow attempt, wrap
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) st(2'd2, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
        rou_valid = 1'b1;
        rou_store = 1'b1;
        rou_waddr = 32'h210;
        rou_wdata = 32'hA4;
        check_all();
        chk("t3_full_ready", sq_ready, 0);
        tick();
        rou_valid = 1'b0;
        wait_req();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        mem_done  = 1'b1;
        check_all();
        chk("t3_pop_ready", sq_ready, 0);
        tick();
        mem_done = 1'b0;
        check_all();
        chk("t3_after_pop_ready", sq_ready, 1);
        tick();
        st(2'd2, 32'h220, 32'hB0);
        drain();
        st(2'd2, 32'h224, 32'hB1);
        st(2'd2, 32'h228, 32'hB2);
        drain();

        // forwarding
        mem_ready = 1'b0;
        st(2'd2, 32'h100, 32'h1111_1111);
        st(2'd2, 32'h100, 32'h2222_2222);
        ld_valid = 1'b1;
        ld_addr  = 32'h102;
        check_all();
        chk("t4_hit", ld_fwd_hit, 1);
        chk("t4_data", ld_fwd_data, 32'h2222_2222);
        tick();
        ld_valid = 1'b0;
        drain();
        mem_ready = 1'b0;
        st(2'd0, 32'h100, 32'h5A);
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        check_all();
        chk("t4_stall", ld_stall, 1);
        chk("t4_nohit", ld_fwd_hit, 0);
        tick();
        ld_addr = 32'h200;
        check_all();
        chk("t4_miss_hit", ld_fwd_hit, 0);
        chk("t4_miss_stall", ld_stall, 0);
        tick();
        ld_valid = 1'b0;
        drain();

        // enqueue and pop in the same cycle
        mem_ready = 1'b0;
        st(2'd2, 32'h300, 32'hC0);
        st(2'd2, 32'h304, 32'hC1);
        wait_req();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        mem_done  = 1'b1;
        st(2'd2, 32'h308, 32'hC2);
        mem_done = 1'b0;
        wait_req();
        check_all();
        chk("t5_next_addr", mem_addr, 32'h304);
        chk("t5_next_data", mem_wdata, 32'hC1);
        tick();
        drain();

        // async reset while waiting for an ack
        mem_ready = 1'b0;
        st(2'd2, 32'h400, 32'hD0);
        st(2'd2, 32'h404, 32'hD1);
        st(2'd2, 32'h408, 32'hD2);
        wait_req();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_mvalid", mem_valid, 0);
        chk("t6_empty", sq_empty, 1);
        chk("t6_ready", sq_ready, 1);
        chk("t6_addr", mem_addr, 32'h0);
        model_reset();
        cyc();
        reset = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check_all();
        chk("t6_no_write", mem_valid, 0);
        tick();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = 32'h100 + 32'($urandom_range(0, 15));
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            rou_valid = 1'($urandom_range(0, 1));
            rou_store = ($urandom_range(0, 3) != 0);
            rou_alu   = {3'($urandom_range(0, 7)), sz};
            rou_waddr = a;
            rou_wdata = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            mem_done  = (mst == 2) ? ($urandom_range(0, 2) == 0)
                                   : ($urandom_range(0, 5) == 0);
            ld_valid  = 1'($urandom_range(0, 1));
            ld_addr   = 32'h100 + 32'($urandom_range(0, 19));
            cyc();
        end
        rou_valid = 1'b0;
        ld_valid  = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_sq.md
Name: ysyx_sq

Overview:
Post-commit store queue that sits directly downstream of the reorder/commit unit on the rou_lsu path. It accepts retired stores in program order and drains them one at a time to the data-memory write port. It also offers same-cycle store-to-load forwarding and stall detection for younger loads. Its sq_ready output is the back-pressure the commit stage uses to hold a store at the ROB head.

Parameters:
SQ_SIZE, 4, number of entries; power of two, at least 2
XLEN, 32, address/data width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
rou_valid  in  1  commit stage retiring an instruction this cycle
rou_store  in  1  retiring instruction is a store
rou_alu  in  5  store size code; [1:0]: 00=byte, 01=half, 10=word; [4:2] ignored
rou_waddr  in  XLEN  store byte address
rou_wdata  in  XLEN  store data, unshifted, LSB-aligned
sq_ready  out  1  queue can accept a store this cycle
sq_empty  out  1  no entries held and no write outstanding; used for fence/fence.i drain
mem_valid  out  1  write request valid
mem_ready  in  1  memory accepts the request
mem_addr  out  XLEN  word-aligned address ({waddr[XLEN-1:2],2'b0})
mem_wdata  out  XLEN  byte-lane-shifted data
mem_wstrb  out  4  byte strobes
mem_done  in  1  write acknowledged (1-cycle pulse)
ld_valid  in  1  load lookup request
ld_addr  in  XLEN  load byte address
ld_fwd_hit  out  1  forwarding data is valid
ld_fwd_data  out  XLEN  forwarded word
ld_stall  out  1  load must retry next cycle

Behaviour:
- Storage: circular buffer indexed by head/tail pointers of width $clog2(SQ_SIZE), plus a count of width $clog2(SQ_SIZE)+1. Each entry holds word_addr, shifted data and wstrb.
- Enqueue condition: rou_valid && rou_store && sq_ready. On enqueue, write the entry at tail, increment tail (wraps modulo SQ_SIZE) and increment count. Non-store commits are ignored.
- Strobe generation: off = waddr[1:0]. Byte: 4'b0001<<off. Half: 4'b0011<<off. Word: 4'b1111.
- Data generation: data = wdata << (8*off).
- Misaligned stores do not reach this block; they trap upstream. If a half with off=3 arrives anyway, strobes above bit 3 are truncated.
- sq_ready = (count != SQ_SIZE). It is computed from registered count only, so a pop in the same cycle does not free a slot until the next cycle.
- Drain FSM, states IDLE, REQ, WAIT; reset state IDLE.
  - IDLE: if count != 0, go to REQ.
  - REQ: mem_valid=1, presenting the head entry. If mem_ready, go to WAIT.
  - WAIT: mem_valid=0. On mem_done, pop head (increment head, decrement count). Then go to REQ if count after pop is nonzero, else IDLE.
  - mem_done outside WAIT is ignored.
- The head entry is not removed until mem_done. The entry being written stays visible to forwarding.
- Simultaneous enqueue and pop: count is unchanged; both pointers advance.
- sq_empty = (count == 0) && (state == IDLE).
- Forwarding (combinational, same cycle as ld_valid). Consider all valid entries whose word_addr equals ld_addr[XLEN-1:2]. Pick the youngest match, i.e. the one nearest tail.
  - The load's needed strobes come from its byte address and a word-sized access, i.e. 4'b1111.
  - If the youngest match has wstrb==4'hf: ld_fwd_hit=1, ld_fwd_data = that entry's data, ld_stall=0.
  - Else, if any match exists: ld_stall=1, ld_fwd_hit=0.
  - ld_stall=1 also when an enqueue this cycle targets the same word.
  - No match: hit=0, stall=0, data=0.
  - When ld_valid=0, all three ld_* outputs are 0.
- Reset, asynchronous and immediate: head=tail=count=0, state=IDLE, entries' valid cleared.
  - Output values under reset: sq_ready=1, sq_empty=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, ld_* = 0.
  - Reset in REQ or WAIT drops the outstanding request. The memory side is reset by the same signal.
- Pipeline flushes from the commit stage do not affect this block; all held stores are architecturally committed.

Test Plan:
- Word store to 0x8000_0004, data 0xDEADBEEF, mem_ready=1 and mem_done one cycle later -> enqueue cycle N. mem_valid=1 at N+2 with addr 0x8000_0004, wdata 0xDEADBEEF, wstrb 4'hf. Pop on the mem_done cycle; sq_empty=1 the cycle after.
- Byte store addr 0x8000_0003, data 0x000000AB -> mem_wstrb 4'b1000, mem_wdata 0xAB000000. Half store addr 0x8000_0002, data 0x1234 -> wstrb 4'b1100, wdata 0x12340000.
- Hold mem_ready=0 and enqueue SQ_SIZE=4 stores -> sq_ready=0 after the 4th. A 5th rou_valid&&rou_store is not accepted. Releasing mem_ready and pulsing mem_done -> sq_ready=1 the cycle after the pop. Tail wraps to 0 and order is preserved across wrap.
- Queue holds words 0x100←0x11111111 (older) and 0x100←0x22222222 (younger); ld_addr=0x102 -> ld_fwd_hit=1, ld_fwd_data=0x22222222. Queue holds only byte store to 0x100; ld_addr=0x100 -> ld_stall=1, hit=0. ld_addr=0x200 -> hit=0, stall=0.
- Enqueue and mem_done in the same cycle with count=2 -> count stays 2, head and tail each advance by 1, and the next request shows the following entry.
- Assert reset asynchronously during WAIT with 3 entries held -> mem_valid=0, sq_empty=1, sq_ready=1 immediately without a clock edge. After reset is released, no write is issued.
